// File: rtl/rom_loader_if.sv
// Byte-stream and ROM debug-port signals between rom_loader (master) and its environment (slave).
interface rom_loader_if;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic [31:0] dm_rdata_i;

    modport master (
        input  byte_valid_i, byte_data_i, dm_rdata_i,
        output byte_ready_o, dm_we_o, dm_addr_o, dm_wdata_o
    );

    modport slave (
        output byte_valid_i, byte_data_i, dm_rdata_i,
        input  byte_ready_o, dm_we_o, dm_addr_o, dm_wdata_o
    );
endinterface

// File: rtl/rom_loader.sv
// Packs a byte stream into little-endian words, writes each into instruction ROM,
// reads it back to verify, keeps a running checksum and holds the core while loading.
module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [15:0]        len_i,
    rom_loader_if.master       bus,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               cpu_hold_o,
    output logic [31:0]        checksum_o
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, VERIFY, DONE, ERROR} state_t;

    state_t      state_q, state_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [15:0] len_q, len_d;
    logic [31:0] cks_q, cks_d;
    logic        ready, we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            len_q      <= '0;
            cks_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            len_q      <= len_d;
            cks_q      <= cks_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        len_d      = len_q;
        cks_d      = cks_q;
        ready      = 1'b0;
        we         = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    cks_d      = '0;
                    len_d      = len_i;
                    if (len_i == 16'd0)
                        state_d = DONE;
                    else if ({16'd0, len_i} > MAX_WORDS)
                        state_d = ERROR;
                    else
                        state_d = RECV;
                end
            end
            RECV: begin
                // abort wins: ready is suppressed so no byte is taken on the abort cycle
                if (abort_i) begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                end else begin
                    ready = 1'b1;
                    if (bus.byte_valid_i) begin
                        buf_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data_i;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3)
                            state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (abort_i) begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                end else begin
                    we      = 1'b1;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (abort_i) begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                end else if (bus.dm_rdata_i != buf_q) begin
                    state_d = ERROR;
                end else begin
                    cks_d = cks_q + buf_q;
                    // last word: keep word_cnt so the address stays on it
                    if (word_cnt_q == len_q - 16'd1) begin
                        state_d = DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + 16'd1;
                        state_d    = RECV;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.byte_ready_o = ready;
    assign bus.dm_we_o      = we;
    assign bus.dm_addr_o    = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
    assign bus.dm_wdata_o   = buf_q;

    assign busy_o     = (state_q == RECV) || (state_q == WRITE) || (state_q == VERIFY);
    assign done_o     = (state_q == DONE);
    assign err_o      = (state_q == ERROR);
    assign cpu_hold_o = busy_o || (state_q == ERROR);
    assign checksum_o = cks_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: table of load sessions plus reset and abort sequences.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o, cpu_hold_o;
    logic [31:0] checksum_o;

    rom_loader_if bus ();

    rom_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .len_i      (len_i),
        .bus        (bus.master),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .cpu_hold_o (cpu_hold_o),
        .checksum_o (checksum_o)
    );

    always #5 clk = ~clk;

    // ROM model: write on we, combinational read, optional forced-bad read
    logic [31:0] mem [0:4095];
    logic        bad_read = 1'b0;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          ready_low = 0;

    assign bus.dm_rdata_i = bad_read ? 32'h0 : mem[bus.dm_addr_o[13:2]];

    always @(negedge clk) begin
        if (bus.dm_we_o) begin
            mem[bus.dm_addr_o[13:2]] = bus.dm_wdata_o;
            wr_addr.push_back(bus.dm_addr_o);
            wr_data.push_back(bus.dm_wdata_o);
        end
        if (busy_o && !bus.byte_ready_o)
            ready_low++;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] len;
        int          nbytes;
        logic [63:0] bytes;
        bit          gap;
        bit          corrupt;
        bit          e_done;
        bit          e_err;
        bit          e_hold;
        logic [31:0] e_cks;
        int          e_nw;
        int          e_lat;
        int          e_rlow;
        logic [31:0] e_addr;
        logic [31:0] e_w0;
        logic [31:0] e_w1;
    } vec_t;

    vec_t tbl [6];

    task automatic feed(input logic [63:0] bytes, input int n, input bit gap);
        int idx = 0;
        int budget = 0;
        while (idx < n && budget < 400) begin
            @(negedge clk);
            start_i = 1'b0;
            bus.byte_valid_i = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.byte_data_i  = bytes[8*idx +: 8];
            #1;
            if (bus.byte_valid_i && bus.byte_ready_o)
                idx++;
            @(posedge clk);
            budget++;
        end
        if (idx < n)
            chk("feed_timeout", idx, n);
    endtask

    task automatic start_session(input logic [15:0] len);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = len;
        @(posedge clk);
    endtask

    task automatic run(input vec_t v, output int lat);
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < 4; i++) mem[i] = '0;
        bad_read  = v.corrupt;
        ready_low = 0;
        start_session(v.len);
        feed(v.bytes, v.nbytes, v.gap);
        lat = 0;
        do begin
            @(negedge clk);
            bus.byte_valid_i = 1'b0;
            start_i = 1'b0;
            lat++;
        end while (!(done_o || err_o) && lat < 50);
        bad_read = 1'b0;
    endtask

    task automatic check_vec(input int k, input vec_t v, input int lat);
        string p;
        p = $sformatf("v%0d_", k);
        chk({p, "done"}, 32'(done_o), 32'(v.e_done));
        chk({p, "err"}, 32'(err_o), 32'(v.e_err));
        chk({p, "hold"}, 32'(cpu_hold_o), 32'(v.e_hold));
        chk({p, "busy"}, 32'(busy_o), 32'h0);
        chk({p, "checksum"}, checksum_o, v.e_cks);
        chk({p, "nwrites"}, 32'(wr_data.size()), 32'(v.e_nw));
        chk({p, "latency"}, 32'(lat), 32'(v.e_lat));
        chk({p, "ready_low"}, 32'(ready_low), 32'(v.e_rlow));
        chk({p, "addr"}, bus.dm_addr_o, v.e_addr);
        for (int i = 0; i < wr_data.size() && i < 2; i++) begin
            chk({p, $sformatf("waddr%0d", i)}, wr_addr[i], 32'(i * 4));
            chk({p, $sformatf("wdata%0d", i)}, wr_data[i], (i == 0) ? v.e_w0 : v.e_w1);
        end
    endtask

    initial begin
        int lat;

        tbl[0] = '{len:16'd2, nbytes:8, bytes:64'hDEADBEEF_12345678, gap:0, corrupt:0,
                   e_done:1, e_err:0, e_hold:0, e_cks:32'hF0E21567, e_nw:2, e_lat:3,
                   e_rlow:4, e_addr:32'h4, e_w0:32'h12345678, e_w1:32'hDEADBEEF};
        tbl[1] = '{len:16'd2, nbytes:8, bytes:64'hDEADBEEF_12345678, gap:1, corrupt:0,
                   e_done:1, e_err:0, e_hold:0, e_cks:32'hF0E21567, e_nw:2, e_lat:3,
                   e_rlow:4, e_addr:32'h4, e_w0:32'h12345678, e_w1:32'hDEADBEEF};
        tbl[2] = '{len:16'd2, nbytes:4, bytes:64'h00000000_12345678, gap:0, corrupt:1,
                   e_done:0, e_err:1, e_hold:1, e_cks:32'h0, e_nw:1, e_lat:3,
                   e_rlow:2, e_addr:32'h0, e_w0:32'h12345678, e_w1:32'h0};
        tbl[3] = '{len:16'd0, nbytes:0, bytes:64'h0, gap:0, corrupt:0,
                   e_done:1, e_err:0, e_hold:0, e_cks:32'h0, e_nw:0, e_lat:1,
                   e_rlow:0, e_addr:32'h0, e_w0:32'h0, e_w1:32'h0};
        tbl[4] = '{len:16'd4097, nbytes:0, bytes:64'h0, gap:0, corrupt:0,
                   e_done:0, e_err:1, e_hold:1, e_cks:32'h0, e_nw:0, e_lat:1,
                   e_rlow:0, e_addr:32'h0, e_w0:32'h0, e_w1:32'h0};
        tbl[5] = '{len:16'd1, nbytes:4, bytes:64'h00000000_04030201, gap:1, corrupt:0,
                   e_done:1, e_err:0, e_hold:0, e_cks:32'h04030201, e_nw:1, e_lat:3,
                   e_rlow:2, e_addr:32'h0, e_w0:32'h04030201, e_w1:32'h0};

        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_ready", 32'(bus.byte_ready_o), 32'h0);
        chk("rst_addr", bus.dm_addr_o, 32'h0);
        chk("rst_hold", 32'(cpu_hold_o), 32'h0);
        chk("rst_cks", checksum_o, 32'h0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run(tbl[k], lat);
            check_vec(k, tbl[k], lat);
        end

        // asynchronous reset in the middle of word 1
        start_session(16'd2);
        feed(64'hDEADBEEF_12345678, 6, 1'b0);
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        chk("mid_addr", bus.dm_addr_o, 32'h4);
        chk("mid_hold", 32'(cpu_hold_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy_o), 32'h0);
        chk("async_hold", 32'(cpu_hold_o), 32'h0);
        chk("async_addr", bus.dm_addr_o, 32'h0);
        chk("async_ready", 32'(bus.byte_ready_o), 32'h0);
        chk("async_cks", checksum_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // start ignored mid-session, then abort after 2 bytes of word 1
        wr_addr.delete();
        wr_data.delete();
        start_session(16'd2);
        feed(64'hDEADBEEF_12345678, 6, 1'b0);
        @(negedge clk);
        bus.byte_valid_i = 1'b0;
        start_i = 1'b1;
        len_i   = 16'd0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        chk("ign_start_busy", 32'(busy_o), 32'h1);
        chk("ign_start_done", 32'(done_o), 32'h0);
        abort_i = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.byte_ready_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'h0);
        chk("abort_hold", 32'(cpu_hold_o), 32'h0);
        chk("abort_nwrites", 32'(wr_data.size()), 32'h1);
        chk("abort_cks", checksum_o, 32'h12345678);
        repeat (2) @(negedge clk);
        chk("abort_no_we", 32'(wr_data.size()), 32'h1);

        run(tbl[0], lat);
        check_vec(6, tbl[0], lat);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
